alu_serial_slice: RTL and testbench

Parametrised, multi-cycle ALU that performs 74181-function-table operations on WIDTH-bit operands by iterating one 4-bit slice per clock, LSB nibble first, with the slice carry held in a register between cycles. It generalises the team's single 4-bit 74181 slice to arbitrary multiples of 4 bits and adds a start/ready/done handshake and result flags. It also supports carry chaining across consecutive operations for multi-word arithmetic. It sits behind the datapath register file as the shared arithmetic/logic unit.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_serial_slice_if.sv | 30 +++
 rtl/alu_slice4.sv | 40 ++++
 rtl/alu_serial_slice.sv | 136 +++++++++++++
 tb/tb_alu_serial_slice.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the serial 74181-style ALU.
// Contents:
//   state_e    - controller states (idle, run, done)
//   SEL_*      - commonly used 74181 function selects
//   idx_width  - width of a slice index for a given slice count
package alu_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    // Function selects, active-high data convention.
    localparam logic [3:0] SEL_ADD = 4'b1001;  // m=0: A plus B (plus carry)
    localparam logic [3:0] SEL_SUB = 4'b0110;  // m=0: A minus B minus 1 (plus carry)
    localparam logic [3:0] SEL_XOR = 4'b0110;  // m=1: A xor B

    // Index width for nslice slices; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage

// File: rtl/alu_serial_slice_if.sv
// Request/response bundle for alu_serial_slice.
// master drives: start, a, b, m, s, carry_in, use_prev_carry
// slave drives:  ready, done, result, carry_out, aeqb, zero
interface alu_serial_slice_if #(
    parameter int unsigned WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             m;
    logic [3:0]       s;
    logic             carry_in;
    logic             use_prev_carry;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
    logic             aeqb;
    logic             zero;

    modport master (
        output start, a, b, m, s, carry_in, use_prev_carry,
        input  ready, done, result, carry_out, aeqb, zero
    );

    modport slave (
        input  start, a, b, m, s, carry_in, use_prev_carry,
        output ready, done, result, carry_out, aeqb, zero
    );
endinterface

// File: rtl/alu_slice4.sv
// Combinational 4-bit 74181 function table, active-high data.
// Ports:
//   a, b  in  4  operands
//   s     in  4  function select S3..S0
//   m     in  1  0 = arithmetic, 1 = logic
//   cn    in  1  carry in, active-low
//   f     out 4  function result
//   cn4   out 1  carry out, active-low (held high in logic mode)
//   g, p  out 1  group generate / propagate, active-low
//   aeqb  out 1  high when f is all ones
module alu_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic [3:0] s,
    input  logic       m,
    input  logic       cn,
    output logic [3:0] f,
    output logic       cn4,
    output logic       g,
    output logic       p,
    output logic       aeqb
);
    logic [3:0] u;
    logic [3:0] v;
    logic [4:0] sum;

    always_comb begin
        // Two first-level terms of the 74181: every select is u plus v
        // in arithmetic mode and xnor(u, v) in logic mode. v is always a
        // bitwise subset of u.
        u    = a | (b & {4{s[0]}}) | (~b & {4{s[1]}});
        v    = (a & b & {4{s[3]}}) | (a & ~b & {4{s[2]}});
        sum  = {1'b0, u} + {1'b0, v} + {4'b0000, ~cn};
        f    = m ? ~(u ^ v) : sum[3:0];
        cn4  = m ? 1'b1 : ~sum[4];
        g    = ~(({1'b0, u} + {1'b0, v}) > 5'd15);
        p    = ~(&u);
        aeqb = &f;
    end
endmodule

// File: rtl/alu_serial_slice.sv
// Multi-cycle ALU: applies the 74181 function table to WIDTH-bit operands
// one nibble per clock, LSB first, with the slice carry held in c_q.
// Ports:
//   clk    in  rising-edge clock
//   rst_n  in  asynchronous active-low reset
//   bus    alu_serial_slice_if.slave: start/ready/done handshake, operands
//          a/b/m/s/carry_in/use_prev_carry, result with carry_out/aeqb/zero
module alu_serial_slice
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_serial_slice_if.slave  bus
);
    localparam int unsigned NSLICE = WIDTH / 4;
    localparam int unsigned IdxW   = idx_width(NSLICE);

    state_e                   state_q;
    logic [IdxW-1:0]          idx_q;
    logic [NSLICE-1:0][3:0]   a_q;
    logic [NSLICE-1:0][3:0]   b_q;
    logic                     m_q;
    logic [3:0]               s_q;
    logic                     c_q;
    logic                     carry_flag_q;
    logic [NSLICE-1:0][3:0]   result_q;
    logic                     carry_out_q;
    logic                     aeqb_q;
    logic                     zero_q;
    logic                     aeqb_acc_q;
    logic                     zero_acc_q;
    logic                     ready_q;
    logic                     done_q;

    logic [3:0] slice_f;
    logic       slice_cn4;
    logic       slice_g;
    logic       slice_p;
    logic       slice_aeqb;
    logic       last_slice;
    logic       unused_gp;

    // Single slice, time-multiplexed over the operand nibbles.
    alu_slice4 u_slice (
        .a    (a_q[idx_q]),
        .b    (b_q[idx_q]),
        .s    (s_q),
        .m    (m_q),
        .cn   (~c_q),
        .f    (slice_f),
        .cn4  (slice_cn4),
        .g    (slice_g),
        .p    (slice_p),
        .aeqb (slice_aeqb)
    );

    assign unused_gp  = slice_g ^ slice_p;
    assign last_slice = (idx_q == IdxW'(NSLICE - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            a_q          <= '0;
            b_q          <= '0;
            m_q          <= 1'b0;
            s_q          <= 4'b0000;
            c_q          <= 1'b0;
            carry_flag_q <= 1'b0;
            result_q     <= '0;
            carry_out_q  <= 1'b0;
            aeqb_q       <= 1'b0;
            zero_q       <= 1'b1;
            aeqb_acc_q   <= 1'b1;
            zero_acc_q   <= 1'b1;
            ready_q      <= 1'b1;
            done_q       <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        a_q        <= bus.a;
                        b_q        <= bus.b;
                        m_q        <= bus.m;
                        s_q        <= bus.s;
                        c_q        <= bus.use_prev_carry ? carry_flag_q : bus.carry_in;
                        idx_q      <= '0;
                        aeqb_acc_q <= 1'b1;
                        zero_acc_q <= 1'b1;
                        ready_q    <= 1'b0;
                        state_q    <= StRun;
                    end
                end
                StRun: begin
                    result_q[idx_q] <= slice_f;
                    c_q             <= ~slice_cn4;
                    idx_q           <= idx_q + 1'b1;
                    aeqb_acc_q      <= aeqb_acc_q & slice_aeqb;
                    zero_acc_q      <= zero_acc_q & ~|slice_f;
                    if (last_slice) begin
                        aeqb_q  <= aeqb_acc_q & slice_aeqb;
                        zero_q  <= zero_acc_q & ~|slice_f;
                        // Logic ops leave the chained carry untouched.
                        if (m_q) begin
                            carry_out_q <= 1'b0;
                        end else begin
                            carry_out_q  <= ~slice_cn4;
                            carry_flag_q <= ~slice_cn4;
                        end
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.ready     = ready_q;
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.carry_out = carry_out_q;
    assign bus.aeqb      = aeqb_q;
    assign bus.zero      = zero_q;
endmodule

// File: tb/tb_alu_serial_slice.sv
// Self-checking bench for alu_serial_slice at WIDTH=16: directed cases
// followed by random operations against a word-level 74181 table model.
module tb_alu_serial_slice;
    import alu_pkg::*;

    localparam int unsigned WIDTH  = 16;
    localparam int unsigned NSLICE = WIDTH / 4;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic model_carry;

    alu_serial_slice_if #(.WIDTH(WIDTH)) bus ();

    alu_serial_slice #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Whole-word 74181 table: returns {carry, F}. Arithmetic rows are
    // "x plus y plus cin", with "minus 1" written as plus all-ones.
    function automatic logic [16:0] ref_op(input logic [15:0] a, input logic [15:0] b,
                                           input logic m, input logic [3:0] s,
                                           input logic cin);
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] ones;
        ones = 16'hFFFF;
        if (m) begin
            case (s)
                4'd0:    x = ~a;
                4'd1:    x = ~(a | b);
                4'd2:    x = ~a & b;
                4'd3:    x = 16'h0000;
                4'd4:    x = ~(a & b);
                4'd5:    x = ~b;
                4'd6:    x = a ^ b;
                4'd7:    x = a & ~b;
                4'd8:    x = ~a | b;
                4'd9:    x = ~(a ^ b);
                4'd10:   x = b;
                4'd11:   x = a & b;
                4'd12:   x = ones;
                4'd13:   x = a | ~b;
                4'd14:   x = a | b;
                default: x = a;
            endcase
            return {1'b0, x};
        end
        case (s)
            4'd0:    begin x = a;      y = 16'h0000; end
            4'd1:    begin x = a | b;  y = 16'h0000; end
            4'd2:    begin x = a | ~b; y = 16'h0000; end
            4'd3:    begin x = 16'h0;  y = ones;     end
            4'd4:    begin x = a;      y = a & ~b;   end
            4'd5:    begin x = a | b;  y = a & ~b;   end
            4'd6:    begin x = a;      y = ~b;       end
            4'd7:    begin x = a & ~b; y = ones;     end
            4'd8:    begin x = a;      y = a & b;    end
            4'd9:    begin x = a;      y = b;        end
            4'd10:   begin x = a | ~b; y = a & b;    end
            4'd11:   begin x = a & b;  y = ones;     end
            4'd12:   begin x = a;      y = a;        end
            4'd13:   begin x = a | b;  y = a;        end
            4'd14:   begin x = a | ~b; y = a;        end
            default: begin x = a;      y = ones;     end
        endcase
        return {1'b0, x} + {1'b0, y} + {16'h0000, cin};
    endfunction

    // One operation. done must appear NSLICE edges after the accepting
    // edge (NSLICE+1 cycles counting the accepting cycle), ready stays low
    // until the edge after done. With hold=1 start stays high throughout.
    task automatic run_op(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tm, input logic [3:0] ts, input logic tcin,
                          input logic tupc, input bit hold);
        logic [16:0] expv;
        @(negedge clk);
        chk1({tag, ".ready_idle"}, bus.ready, 1'b1);
        bus.a              = ta;
        bus.b              = tb;
        bus.m              = tm;
        bus.s              = ts;
        bus.carry_in       = tcin;
        bus.use_prev_carry = tupc;
        bus.start          = 1'b1;
        expv = ref_op(ta, tb, tm, ts, tupc ? model_carry : tcin);
        @(posedge clk);
        for (int k = 0; k <= int'(NSLICE); k++) begin
            @(negedge clk);
            if (k == 0) begin
                if (!hold) bus.start = 1'b0;
                // Operand churn after acceptance must not matter.
                bus.a        = 16'($urandom);
                bus.b        = 16'($urandom);
                bus.carry_in = 1'($urandom);
            end
            chk1({tag, ".ready_busy"}, bus.ready, 1'b0);
            chk1({tag, ".done"}, bus.done, k == int'(NSLICE));
            if (k == int'(NSLICE)) begin
                chk16({tag, ".result"}, bus.result, expv[15:0]);
                chk1({tag, ".carry_out"}, bus.carry_out, tm ? 1'b0 : expv[16]);
                chk1({tag, ".aeqb"}, bus.aeqb, &expv[15:0]);
                chk1({tag, ".zero"}, bus.zero, expv[15:0] == 16'h0000);
            end
        end
        @(negedge clk);
        chk1({tag, ".done_gone"}, bus.done, 1'b0);
        chk1({tag, ".ready_back"}, bus.ready, 1'b1);
        bus.start = 1'b0;
        if (!tm) model_carry = expv[16];
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        model_carry        = 1'b0;
        rst_n              = 1'b0;
        bus.start          = 1'b0;
        bus.a              = '0;
        bus.b              = '0;
        bus.m              = 1'b0;
        bus.s              = 4'b0000;
        bus.carry_in       = 1'b0;
        bus.use_prev_carry = 1'b0;

        repeat (2) @(negedge clk);
        chk1("rst.ready", bus.ready, 1'b1);
        chk1("rst.done", bus.done, 1'b0);
        chk16("rst.result", bus.result, 16'h0000);
        chk1("rst.carry_out", bus.carry_out, 1'b0);
        chk1("rst.aeqb", bus.aeqb, 1'b0);
        chk1("rst.zero", bus.zero, 1'b1);
        rst_n = 1'b1;

        run_op("add", 16'h1234, 16'h0FFF, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b0);
        run_op("sub_pos", 16'h000C, 16'h0008, 1'b0, SEL_SUB, 1'b1, 1'b0, 1'b0);
        run_op("sub_neg", 16'h0008, 16'h000C, 1'b0, SEL_SUB, 1'b1, 1'b0, 1'b0);
        run_op("cmp_eq", 16'hBEEF, 16'hBEEF, 1'b0, SEL_SUB, 1'b0, 1'b0, 1'b0);
        run_op("cmp_ne", 16'hBEEF, 16'hBEEE, 1'b0, SEL_SUB, 1'b0, 1'b0, 1'b0);
        run_op("chain_lo", 16'hFFFF, 16'h0001, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b0);
        run_op("chain_hi", 16'h0000, 16'h0000, 1'b0, SEL_ADD, 1'b0, 1'b1, 1'b0);
        run_op("carry_set", 16'h8000, 16'h8000, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b0);
        run_op("logic_xor", 16'hF0F0, 16'hFF00, 1'b1, SEL_XOR, 1'b1, 1'b0, 1'b0);
        run_op("after_logic", 16'h0000, 16'h0000, 1'b0, SEL_ADD, 1'b0, 1'b1, 1'b0);
        run_op("held_start", 16'h0102, 16'h0304, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b1);

        // Leave a carry in the flag, then reset in the middle of an op.
        run_op("pre_rst", 16'hFFFF, 16'hFFFF, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        bus.a     = 16'h1111;
        bus.b     = 16'h2222;
        bus.m     = 1'b0;
        bus.s     = SEL_ADD;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk1("midrst.ready", bus.ready, 1'b1);
        chk1("midrst.done", bus.done, 1'b0);
        chk16("midrst.result", bus.result, 16'h0000);
        chk1("midrst.carry_out", bus.carry_out, 1'b0);
        chk1("midrst.zero", bus.zero, 1'b1);
        model_carry = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 16'h0000, 16'h0000, 1'b0, SEL_ADD, 1'b0, 1'b1, 1'b0);
        run_op("post_rst2", 16'hA5A5, 16'h5A5B, 1'b0, SEL_ADD, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 24; i++) begin
            run_op("rand", 16'($urandom), 16'($urandom), 1'($urandom), 4'($urandom),
                   1'($urandom), $urandom_range(0, 3) == 0, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
